spring_launch_sequencer: RTL and testbench
==========================================

// Module: spring_launch_sequencer
// PURPOSE
//   Sequences the ball-launch spring for the main screen. Sits between the keypad decoder and
//   spring_controller: gates key5 into a spring pull command and counts charge frames while the
//   key is held. After release it waits for the spring to return to rest, then issues a one-cycle
//   launch with a ball speed proportional to charge. It also locks out re-launch until the lane settles.
// PARAMETERS
//   MIN_CHARGE_FRAMES  4                                      frames below which a release is aborted (no launch)
//   MAX_CHARGE_FRAMES  60                                     charge saturation, must be <= 63
//   BASE_SPEED         64                                     launch speed magnitude at zero charge (fixed point)
//   SPEED_PER_FRAME    8                                      added speed magnitude per charge frame (fixed point)
//   LOCKOUT_FRAMES     30                                     minimum frames in LOCKOUT after a launch
//   REST_Y             defines::SCREEN_MAIN_SPRING_TOP_LEFT_Y spring top-left Y at rest
// PORTS
//   clk             in   1       system clock
//   resetN          in   1       asynchronous active-low reset
//   startOfFrame    in   1       one-cycle pulse per video frame
//   enable          in   1       game running; 0 forces IDLE
//   key5IsPressed   in   1       launch key level
//   ballInLane      in   1       ball resting in the launch lane
//   springTopLeftY  in   11 s    current spring position, from spring_controller
//   springPull      out  1       drives key5IsPressed of spring_controller
//   launchPulse     out  1       one-cycle launch strobe to ball controller
//   launchSpeedY    out  int     signed launch Y speed (negative = up); held until next launch
//   chargeLevel     out  6       current charge frame count
//   busy            out  1       state != IDLE
// BEHAVIOUR
//   Reset (async): state=IDLE; springPull=0; launchPulse=0; launchSpeedY=0; chargeLevel=0;
//     lockout counter=0. A reset mid-operation aborts immediately and issues no pulse.
//   States: IDLE, CHARGE, RELEASE, LAUNCH, LOCKOUT. All outputs are registered.
//   IDLE: springPull=0. enable & key5IsPressed & ballInLane -> CHARGE with chargeLevel<=0.
//     Key with no ball in lane: stays IDLE, spring is not pulled.
//   CHARGE: springPull=1. Each startOfFrame increments chargeLevel, saturating at MAX_CHARGE_FRAMES.
//     On the first cycle with key5IsPressed=0:
//       chargeLevel < MIN_CHARGE_FRAMES -> IDLE (abort, chargeLevel<=0).
//       otherwise -> RELEASE, latching speed = -(BASE_SPEED + chargeLevel*SPEED_PER_FRAME).
//     Release and startOfFrame in the same cycle: the decision uses the pre-increment value and
//       the increment is discarded.
//   RELEASE: springPull=0. springTopLeftY <= REST_Y -> LAUNCH. ballInLane=0 -> LOCKOUT, no launch.
//   LAUNCH: exactly one cycle. launchPulse=1 and launchSpeedY<=latched speed in that same cycle.
//     Then -> LOCKOUT with counter<=0.
//   LOCKOUT: counter increments on startOfFrame, saturating at LOCKOUT_FRAMES.
//     Exit to IDLE only when counter==LOCKOUT_FRAMES & key5IsPressed=0, so a held key never re-charges.
//   enable=0 in any state -> IDLE next cycle: springPull=0, chargeLevel=0, no pulse;
//     launchSpeedY keeps its value.
//   Arithmetic: speed computed in 32-bit signed; max magnitude BASE+63*SPEED must fit.
//     chargeLevel is zero-extended before the multiply.
//   Latency: launchPulse asserts 1 cycle after the cycle in which springTopLeftY<=REST_Y is seen in RELEASE.
// TESTING
//   1 ballInLane=1; hold key 10 frames; release; spring returns to REST_Y -> single launchPulse,
//     launchSpeedY=-144, then LOCKOUT.
//   2 Hold key 100 frames -> chargeLevel saturates at 60; on release launchSpeedY=-544.
//   3 Hold key 2 frames then release -> back to IDLE; no launchPulse; launchSpeedY unchanged.
//   4 ballInLane=0, key held -> springPull stays 0, state IDLE.
//   5 Key held continuously after launch -> stays in LOCKOUT past 30 frames; IDLE 1 cycle after release.
//   6 resetN low during CHARGE -> all outputs 0 immediately.
//     enable=0 during RELEASE -> IDLE next cycle, no pulse.
//   7 Key release coincident with startOfFrame at chargeLevel=3 -> abort (pre-increment value used).

Source files
------------

// File: rtl/spring_launch_sequencer.sv
// Launch-spring sequencer: turns the launch key into a spring pull and charges while the key is held.
// Launches once the spring is back at rest, then locks out re-launch until the lane settles.
module spring_launch_sequencer #(
  parameter int unsigned       MIN_CHARGE_FRAMES = 4,
  parameter int unsigned       MAX_CHARGE_FRAMES = 60,
  parameter int unsigned       BASE_SPEED        = 64,
  parameter int unsigned       SPEED_PER_FRAME   = 8,
  parameter int unsigned       LOCKOUT_FRAMES    = 30,
  parameter logic signed [10:0] REST_Y           = 11'sd400
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               enable,
  input  logic               key5IsPressed,
  input  logic               ballInLane,
  input  logic signed [10:0] springTopLeftY,
  output logic               springPull,
  output logic               launchPulse,
  output logic signed [31:0] launchSpeedY,
  output logic [5:0]         chargeLevel,
  output logic               busy
);

  localparam int unsigned CW = 6;
  localparam int unsigned LW = $clog2(LOCKOUT_FRAMES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHARGE,
    S_RELEASE,
    S_LAUNCH,
    S_LOCKOUT
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      charge_q, charge_d;
  logic [LW-1:0]      lock_q, lock_d;
  logic signed [31:0] latch_q, latch_d;
  logic signed [31:0] speed_q, speed_d;
  logic               pulse_q, pulse_d;
  logic               pull_q, pull_d;
  logic               busy_q, busy_d;

  logic [31:0]        mag_c;
  logic signed [31:0] launch_speed_c;

  // Launch speed from the current (pre-increment) charge; negative means up.
  assign mag_c          = 32'(BASE_SPEED) + 32'(charge_q) * 32'(SPEED_PER_FRAME);
  assign launch_speed_c = -$signed(mag_c);

  always_comb begin
    state_d  = state_q;
    charge_d = charge_q;
    lock_d   = lock_q;
    latch_d  = latch_q;
    speed_d  = speed_q;
    pulse_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable && key5IsPressed && ballInLane) begin
          state_d  = S_CHARGE;
          charge_d = '0;
        end
      end
      S_CHARGE: begin
        // A release wins over a coincident frame tick; the tick is dropped.
        if (!key5IsPressed) begin
          if (charge_q < CW'(MIN_CHARGE_FRAMES)) begin
            state_d  = S_IDLE;
            charge_d = '0;
          end else begin
            state_d = S_RELEASE;
            latch_d = launch_speed_c;
          end
        end else if (startOfFrame && (charge_q < CW'(MAX_CHARGE_FRAMES))) begin
          charge_d = charge_q + CW'(1);
        end
      end
      S_RELEASE: begin
        if (springTopLeftY <= REST_Y) begin
          state_d = S_LAUNCH;
          pulse_d = 1'b1;
          speed_d = latch_q;
        end else if (!ballInLane) begin
          state_d = S_LOCKOUT;
          lock_d  = '0;
        end
      end
      S_LAUNCH: begin
        state_d = S_LOCKOUT;
        lock_d  = '0;
      end
      S_LOCKOUT: begin
        if ((lock_q == LW'(LOCKOUT_FRAMES)) && !key5IsPressed) begin
          state_d = S_IDLE;
        end else if (startOfFrame && (lock_q < LW'(LOCKOUT_FRAMES))) begin
          lock_d = lock_q + LW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (!enable) begin
      state_d  = S_IDLE;
      charge_d = '0;
      pulse_d  = 1'b0;
      speed_d  = speed_q;
    end

    pull_d = (state_d == S_CHARGE);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q  <= S_IDLE;
      charge_q <= '0;
      lock_q   <= '0;
      latch_q  <= '0;
      speed_q  <= '0;
      pulse_q  <= 1'b0;
      pull_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      charge_q <= charge_d;
      lock_q   <= lock_d;
      latch_q  <= latch_d;
      speed_q  <= speed_d;
      pulse_q  <= pulse_d;
      pull_q   <= pull_d;
      busy_q   <= busy_d;
    end
  end

  assign springPull   = pull_q;
  assign launchPulse  = pulse_q;
  assign launchSpeedY = speed_q;
  assign chargeLevel  = charge_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_spring_launch_sequencer.sv
// Bench for spring_launch_sequencer: directed launch scenarios plus random traffic,
// every cycle compared against a behavioural model of the launch sequence.
module tb_spring_launch_sequencer;

  localparam int REST = 400;
  localparam int MINC = 4;
  localparam int MAXC = 60;
  localparam int BASE = 64;
  localparam int SPF  = 8;
  localparam int LOCK = 30;

  logic               clk = 1'b0;
  logic               resetN;
  logic               startOfFrame;
  logic               enable;
  logic               key5IsPressed;
  logic               ballInLane;
  logic signed [10:0] springTopLeftY;
  logic               springPull;
  logic               launchPulse;
  logic signed [31:0] launchSpeedY;
  logic [5:0]         chargeLevel;
  logic               busy;

  int vectors = 0;
  int miscompares = 0;

  spring_launch_sequencer #(
    .MIN_CHARGE_FRAMES(MINC), .MAX_CHARGE_FRAMES(MAXC), .BASE_SPEED(BASE),
    .SPEED_PER_FRAME(SPF), .LOCKOUT_FRAMES(LOCK), .REST_Y(11'(REST))
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .enable(enable),
    .key5IsPressed(key5IsPressed), .ballInLane(ballInLane), .springTopLeftY(springTopLeftY),
    .springPull(springPull), .launchPulse(launchPulse), .launchSpeedY(launchSpeedY),
    .chargeLevel(chargeLevel), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural model: which phase of the launch we are in, plus frame counts.
  string m_phase;
  int    m_charge, m_lock, m_pending, m_speed;
  bit    m_pulse;

  task automatic chk(input string tag, input longint obs, input longint exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_phase = "idle"; m_charge = 0; m_lock = 0; m_pending = 0; m_speed = 0; m_pulse = 0;
  endfunction

  function automatic void model_step(bit en, bit key, bit ball, bit sof, int y);
    m_pulse = 0;
    if (!en) begin
      m_phase = "idle"; m_charge = 0;
      return;
    end
    if (m_phase == "idle") begin
      if (key && ball) begin m_phase = "charge"; m_charge = 0; end
    end else if (m_phase == "charge") begin
      if (!key) begin
        if (m_charge < MINC) begin m_phase = "idle"; m_charge = 0; end
        else begin m_phase = "release"; m_pending = -(BASE + m_charge * SPF); end
      end else if (sof) begin
        m_charge = (m_charge + 1 > MAXC) ? MAXC : m_charge + 1;
      end
    end else if (m_phase == "release") begin
      if (y <= REST) begin m_phase = "launch"; m_pulse = 1; m_speed = m_pending; end
      else if (!ball) begin m_phase = "lockout"; m_lock = 0; end
    end else if (m_phase == "launch") begin
      m_phase = "lockout"; m_lock = 0;
    end else begin
      if (m_lock == LOCK && !key) m_phase = "idle";
      else if (sof) m_lock = (m_lock + 1 > LOCK) ? LOCK : m_lock + 1;
    end
  endfunction

  task automatic check_all();
    chk("springPull",   springPull,   m_phase == "charge");
    chk("launchPulse",  launchPulse,  m_pulse);
    chk("launchSpeedY", launchSpeedY, m_speed);
    chk("chargeLevel",  chargeLevel,  m_charge);
    chk("busy",         busy,         m_phase != "idle");
  endtask

  // One cycle: compare outputs at the falling edge, then apply new inputs.
  task automatic step(input bit en, input bit key, input bit ball, input bit sof, input int y);
    @(negedge clk);
    check_all();
    enable = en; key5IsPressed = key; ballInLane = ball; startOfFrame = sof;
    springTopLeftY = 11'(y);
    model_step(en, key, ball, sof, y);
  endtask

  task automatic frames(input int n, input bit key, input bit ball, input int y);
    for (int f = 0; f < n; f++) begin
      for (int c = 0; c < 3; c++) step(1, key, ball, 0, y);
      step(1, key, ball, 1, y);
    end
  endtask

  // Full launch: charge n frames, release, spring returns, one launch.
  task automatic launch(input int n);
    step(1, 1, 1, 0, REST + 20);
    frames(n, 1, 1, REST + 20);
    step(1, 0, 1, 0, REST + 20);
    step(1, 0, 1, 0, REST + 10);
    step(1, 0, 1, 0, REST);
    step(1, 0, 1, 0, REST);
    step(1, 0, 1, 0, REST);
  endtask

  initial begin
    resetN = 1'b0; enable = 0; key5IsPressed = 0; ballInLane = 0; startOfFrame = 0;
    springTopLeftY = 11'(REST);
    model_reset();
    #12 resetN = 1'b1;

    // Test 1: 10 frames of charge -> single launch at -144, then lockout.
    launch(10);
    @(negedge clk); chk("t1_speed", launchSpeedY, -144);
    frames(32, 0, 1, REST);
    step(1, 0, 1, 0, REST);

    // Test 2: charge saturates at 60 -> -544.
    step(1, 1, 1, 0, REST + 20);
    frames(100, 1, 1, REST + 20);
    @(negedge clk); chk("t2_sat", chargeLevel, 60);
    step(1, 0, 1, 0, REST + 20);
    step(1, 0, 1, 0, REST);
    step(1, 0, 1, 0, REST);
    @(negedge clk); chk("t2_speed", launchSpeedY, -544);
    frames(32, 0, 1, REST);
    step(1, 0, 1, 0, REST);

    // Test 3: short press aborts, speed untouched.
    step(1, 1, 1, 0, REST);
    frames(2, 1, 1, REST);
    step(1, 0, 1, 0, REST);
    step(1, 0, 1, 0, REST);
    step(1, 0, 1, 0, REST);
    chk("t3_speed", launchSpeedY, -544);
    chk("t3_busy", busy, 0);

    // Test 4: key without ball never pulls the spring.
    frames(5, 1, 0, REST);
    step(1, 0, 0, 0, REST);
    chk("t4_pull", springPull, 0);

    // Test 5: key held through lockout keeps it busy; exits once released.
    launch(6);
    frames(40, 1, 1, REST);
    step(1, 1, 1, 0, REST);
    chk("t5_busy_held", busy, 1);
    step(1, 0, 1, 0, REST);
    step(1, 0, 1, 0, REST);
    step(1, 0, 1, 0, REST);

    // Test 6a: reset in CHARGE clears all outputs at once.
    step(1, 1, 1, 0, REST);
    frames(5, 1, 1, REST);
    #2 resetN = 1'b0;
    #1;
    chk("t6_rst_pull", springPull, 0);
    chk("t6_rst_charge", chargeLevel, 0);
    chk("t6_rst_speed", launchSpeedY, 0);
    chk("t6_rst_busy", busy, 0);
    model_reset();
    @(negedge clk); resetN = 1'b1;
    enable = 0; key5IsPressed = 0; startOfFrame = 0;

    // Test 6b: enable drop in RELEASE -> idle, no pulse.
    step(1, 1, 1, 0, REST + 20);
    frames(5, 1, 1, REST + 20);
    step(1, 0, 1, 0, REST + 20);
    step(1, 0, 1, 0, REST + 20);
    step(0, 0, 1, 0, REST);
    step(1, 0, 1, 0, REST);
    chk("t6_en_busy", busy, 0);
    step(1, 0, 1, 0, REST);

    // Test 7: release coincident with frame tick at charge 3 aborts.
    step(1, 1, 1, 0, REST);
    frames(3, 1, 1, REST);
    step(1, 1, 1, 0, REST);
    chk("t7_pre", chargeLevel, 3);
    step(1, 0, 1, 1, REST);
    step(1, 0, 1, 0, REST);
    chk("t7_charge", chargeLevel, 0);
    chk("t7_busy", busy, 0);

    // Random traffic.
    begin
      bit key = 0;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 19) == 0) key = ~key;
        step($urandom_range(0, 49) != 0, key, $urandom_range(0, 19) != 0,
             $urandom_range(0, 3) == 0, REST - 2 + int'($urandom_range(0, 5)));
      end
    end
    step(1, 0, 1, 0, REST);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
